term_writer: RTL and testbench
==============================

# term_writer

Character-stream front end of the text terminal. Consumes a byte stream over a valid/ready handshake and interprets a small set of control codes. Maintains the cursor and current attribute, and issues writes into the 60×17 text/attribute screen memory. The LCD text renderer scans that memory. Scrolling is done by rotating a top-row offset that the renderer adds to its row index, so the block never needs read-back.

## Interface
- COLS, 60, character columns (480 px / 8)
- ROWS, 17, character rows (272 px / 16)
- DEF_ATTR, 8'h07, attribute after reset: [3:0] foreground, [7:4] background palette index
- lcd_clk  in  1  pixel/system clock; the only clock
- lcd_rst  in  1  synchronous, active-high reset
- in_data  in  8  byte to interpret
- in_valid  in  1  in_data valid
- in_ready  out  1  block can accept a byte this cycle
- wr_en  out  1  screen-memory write strobe
- wr_addr  out  10  physical cell address = phys_row*COLS + col
- wr_char  out  8  glyph code
- wr_attr  out  8  attribute byte
- top_row  out  5  physical row shown as logical row 0 (0..ROWS-1)
- cur_col  out  6  cursor column (0..COLS-1)
- cur_row  out  5  cursor logical row (0..ROWS-1)

## Operation
- A byte is accepted when in_valid & in_ready. Accepted bytes are never dropped silently except the codes listed as ignored below.
- States:
  - IDLE: in_ready=1.
  - CLR_ROW: writes COLS blank cells; in_ready=0.
  - CLR_ALL: writes COLS*ROWS blank cells; in_ready=0.
  - A blank cell is char 0x20 with the current attribute.
- Byte decode in IDLE:
  - ≥0x20: write the byte at the cursor, then advance col.
    - col==COLS-1 wraps to col 0 with a newline.
  - 0x0A LF: newline.
  - 0x0D CR: col←0.
  - 0x08 BS: col←col-1 if col>0; no write.
  - 0x0C FF: cursor←(0,0), top_row←0, go to CLR_ALL.
  - Other codes <0x20: ignored.
- Newline:
  - If row<ROWS-1: row+1.
  - Else row stays ROWS-1, top_row←(top_row+1) mod ROWS, and the FSM goes to CLR_ROW for physical row (old top_row). That row is the new bottom.
- Physical row = (top_row + cur_row) mod ROWS. Compute it with compare-and-subtract, not a divider.
- Wrap and scroll in the same byte (printable at col COLS-1, row ROWS-1): the char is written first, then the scroll/clear happens.

## Timing
- Reset values:
  - in_ready=0, wr_en=0, wr_addr=0, wr_char=0x20, wr_attr=DEF_ATTR.
  - top_row=0, cur_col=0, cur_row=0.
  - The FSM then enters CLR_ALL, so the screen is blanked after reset.
- Printable byte accepted in cycle N → wr_en=1 with its address, char and attr in cycle N+1. The cursor outputs update in N+1.
- Back-to-back printables sustain one write per cycle.
- CLR_ROW: wr_en high for exactly COLS consecutive cycles starting the cycle after acceptance, addresses ascending. in_ready rises the cycle after the last write.
- CLR_ALL: COLS*ROWS = 1020 consecutive writes, addresses 0..1019. in_ready rises the cycle after the last write.
- in_ready is registered and does not depend combinationally on in_valid.
- lcd_rst asserted mid-clear aborts the clear. The block restarts from reset values and performs a full CLR_ALL.
- Address arithmetic: phys_row*COLS is formed as (phys_row<<6)-(phys_row<<2). All address values fit in 10 bits.

## Configuration
- Macro TERM_ATTR_CMD_EN.
- Defined:
  - 0x1B (ESC) is accepted and consumed with no write, and arms an attribute latch.
  - The next accepted byte, whatever its value, becomes the current attribute, with no write and no cursor move.
  - ESC with the latch already armed is itself taken as the attribute value.
- Undefined: 0x1B is ignored like the other codes <0x20, and the attribute stays DEF_ATTR permanently.

## Structure
- Package term_pkg holds:
  - COLS, ROWS, DEF_ATTR, BLANK_CHAR (0x20).
  - Control-code constants (BS, LF, FF, CR, ESC).
  - The FSM state typedef (IDLE, CLR_ROW, CLR_ALL).
- Sub-module term_addr_gen: combinational/registered phys_row and wr_addr from top_row, row and col. Shared with the renderer's offset logic.

## Test plan
- Reset → in_ready low 1020 cycles; 1020 writes to addrs 0..1019 of 0x20/0x07; then in_ready=1.
- Send "AB" → writes 0x41@0 and 0x42@1 on consecutive cycles; cur_col=2.
- 60 × 'x' then 'y' → 'y' written at addr 60 (row 1, col 0); cur_row=1, cur_col=1.
- Cursor at row 16, send LF → top_row=1; 60 writes of 0x20 to addrs 0..59; cur_row stays 16. Next 'Z' at col 0 goes to addr 0.
- CR at col 5 → cur_col=0, no write. BS at col 0 → no change.
- With TERM_ATTR_CMD_EN: ESC, 0x1E, 'Q' → 'Q' written with attr 0x1E. Without it: written with 0x07.

Source files
------------

// File: rtl/term_pkg.sv
// Shared constants, control codes and FSM state type for the text terminal writer.
package term_pkg;

  localparam int COLS = 60;
  localparam int ROWS = 17;

  localparam logic [7:0] DEF_ATTR   = 8'h07;
  localparam logic [7:0] BLANK_CHAR = 8'h20;

  localparam logic [7:0] BS  = 8'h08;
  localparam logic [7:0] LF  = 8'h0A;
  localparam logic [7:0] FF  = 8'h0C;
  localparam logic [7:0] CR  = 8'h0D;
  localparam logic [7:0] ESC = 8'h1B;

  localparam logic [5:0] COL_LAST     = 6'(COLS - 1);
  localparam logic [4:0] ROW_LAST     = 5'(ROWS - 1);
  localparam logic [9:0] ROW_CELLS    = 10'(COLS);
  localparam logic [9:0] SCREEN_CELLS = 10'(COLS * ROWS);

  typedef enum logic [1:0] {
    IDLE,
    CLR_ROW,
    CLR_ALL
  } term_state_e;

  // row*COLS without a multiplier: (row<<6) - (row<<2)
  function automatic logic [9:0] row_base(input logic [4:0] row);
    logic [10:0] r;
    r = {6'd0, row};
    return 10'((r << 6) - (r << 2));
  endfunction

endpackage

// File: rtl/term_writer_if.sv
// Byte-stream input and screen-memory write port of the terminal writer.
interface term_writer_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       wr_en;
  logic [9:0] wr_addr;
  logic [7:0] wr_char;
  logic [7:0] wr_attr;

  modport master (
    output in_data, in_valid,
    input  in_ready, wr_en, wr_addr, wr_char, wr_attr
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, wr_en, wr_addr, wr_char, wr_attr
  );
endinterface

// File: rtl/term_addr_gen.sv
// Logical-to-physical row mapping and cell address; the renderer uses the same mapping.
module term_addr_gen
  import term_pkg::*;
(
  input  logic [4:0] top_row,
  input  logic [4:0] row,
  input  logic [5:0] col,
  output logic [4:0] phys_row,
  output logic [9:0] addr
);

  logic [5:0] sum;

  always_comb begin
    sum      = {1'b0, top_row} + {1'b0, row};
    phys_row = (sum >= 6'(ROWS)) ? 5'(sum - 6'(ROWS)) : sum[4:0];
    addr     = row_base(phys_row) + {4'd0, col};
  end

endmodule

// File: rtl/term_writer.sv
// Character-stream front end: decodes bytes, tracks cursor/attribute, writes screen memory.
// Optional build macro TERM_ATTR_CMD_EN enables ESC-prefixed attribute changes.
module term_writer
  import term_pkg::*;
(
  input  logic         lcd_clk,
  input  logic         lcd_rst,
  term_writer_if.slave bus,
  output logic [4:0]   top_row,
  output logic [5:0]   cur_col,
  output logic [4:0]   cur_row
);

  term_state_e state, state_nxt;
  logic [9:0]  cnt, cnt_nxt;
  logic [9:0]  clr_addr, clr_addr_nxt;
  logic        rdy, rdy_nxt;
  logic        wen, wen_nxt;
  logic [9:0]  waddr, waddr_nxt;
  logic [7:0]  wchar, wchar_nxt;
  logic [7:0]  wattr, wattr_nxt;
  logic [7:0]  attr, attr_nxt;
  logic [4:0]  top, top_nxt;
  logic [4:0]  row, row_nxt;
  logic [5:0]  col, col_nxt;
`ifdef TERM_ATTR_CMD_EN
  logic        esc_armed, esc_nxt;
`endif

  logic        accept;
  logic        newline;
  logic        clear_now;
  logic [4:0]  cell_phys;
  logic [9:0]  cell_addr;
  logic [4:0]  bottom_next;
  logic [9:0]  scroll_base;

  term_addr_gen u_addr_gen (
    .top_row  (top),
    .row      (row),
    .col      (col),
    .phys_row (cell_phys),
    .addr     (cell_addr)
  );

  // A scroll only happens with the cursor on the bottom row; the row after it
  // (i.e. the old top row) becomes the new, blank bottom row.
  assign bottom_next = (cell_phys == ROW_LAST) ? 5'd0 : cell_phys + 5'd1;
  assign scroll_base = row_base(bottom_next);
  assign accept      = bus.in_valid & rdy;

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    clr_addr_nxt = clr_addr;
    wen_nxt      = 1'b0;
    waddr_nxt    = waddr;
    wchar_nxt    = wchar;
    wattr_nxt    = wattr;
    attr_nxt     = attr;
    top_nxt      = top;
    row_nxt      = row;
    col_nxt      = col;
`ifdef TERM_ATTR_CMD_EN
    esc_nxt      = esc_armed;
`endif
    newline      = 1'b0;
    clear_now    = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
`ifdef TERM_ATTR_CMD_EN
          if (esc_armed) begin
            attr_nxt = bus.in_data;
            esc_nxt  = 1'b0;
          end else if (bus.in_data == ESC) begin
            esc_nxt = 1'b1;
          end else
`endif
          if (bus.in_data >= BLANK_CHAR) begin
            wen_nxt   = 1'b1;
            waddr_nxt = cell_addr;
            wchar_nxt = bus.in_data;
            wattr_nxt = attr;
            if (col == COL_LAST) begin
              col_nxt = 6'd0;
              newline = 1'b1;
            end else begin
              col_nxt = col + 6'd1;
            end
          end else begin
            case (bus.in_data)
              LF: begin
                newline   = 1'b1;
                clear_now = 1'b1;
              end
              CR: col_nxt = 6'd0;
              BS: if (col != 6'd0) col_nxt = col - 6'd1;
              FF: begin
                col_nxt      = 6'd0;
                row_nxt      = 5'd0;
                top_nxt      = 5'd0;
                state_nxt    = CLR_ALL;
                wen_nxt      = 1'b1;
                waddr_nxt    = 10'd0;
                wchar_nxt    = BLANK_CHAR;
                wattr_nxt    = attr;
                clr_addr_nxt = 10'd1;
                cnt_nxt      = 10'd1;
              end
              default: ;
            endcase
          end
        end

        // A bare LF starts clearing at once; a wrapping printable writes its glyph first.
        if (newline) begin
          if (row != ROW_LAST) begin
            row_nxt = row + 5'd1;
          end else begin
            top_nxt   = (top == ROW_LAST) ? 5'd0 : top + 5'd1;
            state_nxt = CLR_ROW;
            if (clear_now) begin
              wen_nxt      = 1'b1;
              waddr_nxt    = scroll_base;
              wchar_nxt    = BLANK_CHAR;
              wattr_nxt    = attr;
              clr_addr_nxt = scroll_base + 10'd1;
              cnt_nxt      = 10'd1;
            end else begin
              clr_addr_nxt = scroll_base;
              cnt_nxt      = 10'd0;
            end
          end
        end
      end

      CLR_ROW, CLR_ALL: begin
        if (cnt == ((state == CLR_ROW) ? ROW_CELLS : SCREEN_CELLS)) begin
          state_nxt = IDLE;
        end else begin
          wen_nxt      = 1'b1;
          waddr_nxt    = clr_addr;
          wchar_nxt    = BLANK_CHAR;
          wattr_nxt    = attr;
          clr_addr_nxt = clr_addr + 10'd1;
          cnt_nxt      = cnt + 10'd1;
        end
      end

      default: state_nxt = IDLE;
    endcase

    rdy_nxt = (state_nxt == IDLE);
  end

  always_ff @(posedge lcd_clk) begin
    if (lcd_rst) begin
      state     <= CLR_ALL;
      cnt       <= 10'd0;
      clr_addr  <= 10'd0;
      rdy       <= 1'b0;
      wen       <= 1'b0;
      waddr     <= 10'd0;
      wchar     <= BLANK_CHAR;
      wattr     <= DEF_ATTR;
      attr      <= DEF_ATTR;
      top       <= 5'd0;
      row       <= 5'd0;
      col       <= 6'd0;
`ifdef TERM_ATTR_CMD_EN
      esc_armed <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      clr_addr  <= clr_addr_nxt;
      rdy       <= rdy_nxt;
      wen       <= wen_nxt;
      waddr     <= waddr_nxt;
      wchar     <= wchar_nxt;
      wattr     <= wattr_nxt;
      attr      <= attr_nxt;
      top       <= top_nxt;
      row       <= row_nxt;
      col       <= col_nxt;
`ifdef TERM_ATTR_CMD_EN
      esc_armed <= esc_nxt;
`endif
    end
  end

  assign bus.in_ready = rdy;
  assign bus.wr_en    = wen;
  assign bus.wr_addr  = waddr;
  assign bus.wr_char  = wchar;
  assign bus.wr_attr  = wattr;
  assign top_row      = top;
  assign cur_col      = col;
  assign cur_row      = row;

endmodule

// File: tb/tb_term_writer.sv
// Randomised bench for term_writer against a screen-level reference model with a write scoreboard.
module tb_term_writer;

  localparam int M_COLS  = 60;
  localparam int M_ROWS  = 17;
  localparam int M_CELLS = M_COLS * M_ROWS;
`ifdef TERM_ATTR_CMD_EN
  localparam bit ESC_EN = 1'b1;
`else
  localparam bit ESC_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  term_writer_if bus();
  logic [4:0] top_row;
  logic [5:0] cur_col;
  logic [4:0] cur_row;

  term_writer dut (
    .lcd_clk (clk),
    .lcd_rst (rst),
    .bus     (bus),
    .top_row (top_row),
    .cur_col (cur_col),
    .cur_row (cur_row)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [9:0] a;
    logic [7:0] c;
    logic [7:0] at;
  } wr_t;

  wr_t        exp_q[$];
  int         m_col, m_row, m_top;
  logic [7:0] m_attr;
  bit         m_esc;
  bit         m_wr_now;

  function automatic void exp_wr(input int a, input logic [7:0] c, input logic [7:0] at);
    wr_t w;
    w.a  = 10'(a);
    w.c  = c;
    w.at = at;
    exp_q.push_back(w);
  endfunction

  function automatic void m_newline();
    if (m_row < M_ROWS - 1) m_row++;
    else begin
      for (int c = 0; c < M_COLS; c++) exp_wr(m_top * M_COLS + c, 8'h20, m_attr);
      m_top    = (m_top + 1) % M_ROWS;
      m_wr_now = 1'b1;
    end
  endfunction

  function automatic void m_accept(input logic [7:0] b);
    m_wr_now = 1'b0;
    if (ESC_EN && m_esc) begin
      m_attr = b;
      m_esc  = 1'b0;
    end else if (ESC_EN && b == 8'h1B) begin
      m_esc = 1'b1;
    end else if (b >= 8'h20) begin
      exp_wr(((m_top + m_row) % M_ROWS) * M_COLS + m_col, b, m_attr);
      m_wr_now = 1'b1;
      if (m_col == M_COLS - 1) begin
        m_col = 0;
        m_newline();
      end else m_col++;
    end else begin
      case (b)
        8'h0A: m_newline();
        8'h0D: m_col = 0;
        8'h08: if (m_col > 0) m_col--;
        8'h0C: begin
          m_col = 0;
          m_row = 0;
          m_top = 0;
          for (int i = 0; i < M_CELLS; i++) exp_wr(i, 8'h20, m_attr);
          m_wr_now = 1'b1;
        end
        default: ;
      endcase
    end
  endfunction

  function automatic void m_reset();
    m_col  = 0;
    m_row  = 0;
    m_top  = 0;
    m_attr = 8'h07;
    m_esc  = 1'b0;
    exp_q.delete();
    for (int i = 0; i < M_CELLS; i++) exp_wr(i, 8'h20, 8'h07);
  endfunction

  // ---------------- write monitor ----------------
  logic rst_q = 1'b1;
  int   n_writes = 0;
  int   n_gaps = 0;

  always @(posedge clk) rst_q <= rst;

  always @(negedge clk) begin
    if (!rst_q) begin
      if (!bus.in_ready && !bus.wr_en) n_gaps++;
      if (bus.wr_en) begin
        n_writes++;
        if (exp_q.size() == 0) chk("wr_unexpected", 32'(bus.wr_addr), 32'h3ff);
        else begin : pop
          wr_t w;
          w = exp_q.pop_front();
          chk("wr_addr", 32'(bus.wr_addr), 32'(w.a));
          chk("wr_char", 32'(bus.wr_char), 32'(w.c));
          chk("wr_attr", 32'(bus.wr_attr), 32'(w.at));
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    int t;
    t = 0;
    while (!bus.in_ready && t < 3000) begin
      tick();
      t++;
    end
    if (!bus.in_ready) begin
      chk("send_timeout", 32'(bus.in_ready), 32'd1);
      return;
    end
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    m_accept(b);
    tick();
    bus.in_valid = 1'b0;
    chk("wr_en_next", 32'(bus.wr_en), 32'(m_wr_now));
    chk("cur_col", 32'(cur_col), 32'(m_col));
    chk("cur_row", 32'(cur_row), 32'(m_row));
    chk("top_row", 32'(top_row), 32'(m_top));
  endtask

  task automatic wait_idle(input string tag, input int exp_writes);
    int w0;
    int t;
    w0 = n_writes;
    t  = 0;
    while (!bus.in_ready && t < 3000) begin
      tick();
      t++;
    end
    chk({tag, "_ready"}, 32'(bus.in_ready), 32'd1);
    if (exp_writes >= 0) chk({tag, "_writes"}, 32'(n_writes - w0), 32'(exp_writes));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    chk({tag, "_wr_en"},    32'(bus.wr_en),    32'd0);
    chk({tag, "_wr_addr"},  32'(bus.wr_addr),  32'd0);
    chk({tag, "_wr_char"},  32'(bus.wr_char),  32'h20);
    chk({tag, "_wr_attr"},  32'(bus.wr_attr),  32'h07);
    chk({tag, "_top_row"},  32'(top_row),      32'd0);
    chk({tag, "_cur_col"},  32'(cur_col),      32'd0);
    chk({tag, "_cur_row"},  32'(cur_row),      32'd0);
  endtask

  task automatic send_random(input int n);
    logic [7:0] b;
    int r;
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 99);
      if (r < 60)      b = 8'($urandom_range(32, 126));
      else if (r < 70) b = 8'h0A;
      else if (r < 76) b = 8'h0D;
      else if (r < 82) b = 8'h08;
      else if (r < 86) b = 8'h1B;
      else if (r < 95) b = 8'($urandom_range(0, 31));
      else if ($urandom_range(0, 9) == 0) b = 8'h0C;
      else             b = 8'($urandom_range(160, 255));
      send(b);
    end
  endtask

  initial begin
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    m_reset();

    rst = 1'b1;
    repeat (3) tick();
    chk_reset("rst");
    rst = 1'b0;
    wait_idle("init_clear", M_CELLS);

    send(8'h41);
    send(8'h42);

    send(8'h0D);
    repeat (M_COLS) send(8'h78);
    send(8'h79);

    repeat (15) send(8'h0A);
    send(8'h0A);
    wait_idle("scroll", M_COLS - 1);
    send(8'h0D);
    send(8'h5A);

    send(8'h0D);
    repeat (5) send(8'h2E);
    send(8'h0D);
    send(8'h08);

    send(8'h1B);
    send(8'h1E);
    send(8'h51);

    send(8'h0D);
    repeat (M_COLS - 1) send(8'h20);
    send(8'h57);
    wait_idle("wrap_scroll", M_COLS);

    send(8'h0C);
    wait_idle("ff_clear", M_CELLS - 1);

    send_random(400);
    wait_idle("rand1", -1);

    send(8'h0C);
    repeat (200) tick();
    rst = 1'b1;
    repeat (2) tick();
    chk_reset("rst_mid");
    m_reset();
    rst = 1'b0;
    wait_idle("rst_mid_clear", M_CELLS);

    send_random(150);
    wait_idle("rand2", -1);
    repeat (2) tick();

    chk("exp_q_left", 32'(exp_q.size()), 32'd0);
    chk("busy_gaps", 32'(n_gaps), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
